fifo_ctrl: RTL and testbench

//  Pointer/flag controller for the FIFO. Sits directly upstream of the dual-port FIFO RAM.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ptr.sv | 19 +
 rtl/fifo_ctrl.sv | 100 ++++++++++
 tb/tb_fifo_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO: RAM geometry, pointer and occupancy-state types.
package fifo_pkg;
    localparam int MATRIX_SIZE = 16;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = $clog2(MATRIX_SIZE);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] M_address_t;
    // One extra MSB so that equal low bits can be told apart as full vs empty.
    typedef logic [ADDR_W:0]   ptr_t;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_t;
endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around FIFO pointer: advances by one per accepted operation, MSB toggles on wrap.
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output ptr_t ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ptr_t'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: gates push/pop into RAM enables, tracks occupancy with a
// three-state FSM, and raises sticky overflow/underflow flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = MATRIX_SIZE,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    output logic          wr_en,
    output logic          rd_en,
    output logic [AW-1:0] count_push,
    output logic [AW-1:0] count_pop,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   usedw,
    output logic          data_valid,
    output logic          overflow,
    output logic          underflow,
    output fifo_state_t   state
);

    fifo_state_t state_next;
    logic [AW:0] usedw_next;
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;

    // Flags come from the registered state, so the enables never depend on this cycle's ops.
    assign full  = (state == FULL);
    assign empty = (state == EMPTY);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    fifo_ptr u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_en),
        .ptr (wr_ptr)
    );

    fifo_ptr u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_en),
        .ptr (rd_ptr)
    );

    assign count_push = wr_ptr[AW-1:0];
    assign count_pop  = rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            usedw      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_next;
            usedw      <= usedw_next;
            data_valid <= rd_en;
            overflow   <= overflow | (push & full);
            underflow  <= underflow | (pop & empty);
        end
    end

    always_comb begin
        state_next = state;
        usedw_next = usedw;
        if (wr_en && !rd_en) begin
            usedw_next = usedw + (AW+1)'(1);
        end else if (rd_en && !wr_en) begin
            usedw_next = usedw - (AW+1)'(1);
        end
        case (state)
            EMPTY: begin
                if (wr_en) begin
                    state_next = (DEPTH == 1) ? FULL : PARTIAL;
                end
            end
            PARTIAL: begin
                if (wr_en && !rd_en && usedw == (AW+1)'(DEPTH-1)) begin
                    state_next = FULL;
                end else if (rd_en && !wr_en && usedw == (AW+1)'(1)) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (rd_en) begin
                    state_next = PARTIAL;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios then random traffic, checked against a queue model
// of the FIFO contents and a registered-read RAM model driven by the DUT's enables/addresses.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    data_t         din;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] count_push;
    logic [AW-1:0] count_pop;
    logic          full;
    logic          empty;
    logic [AW:0]   usedw;
    logic          data_valid;
    logic          overflow;
    logic          underflow;
    fifo_state_t   state;

    data_t         mem [DEPTH];
    data_t         ram_dout;

    data_t         model_q[$];
    int            wr_cnt;
    int            rd_cnt;
    bit            m_ovf;
    bit            m_udf;
    bit            m_dv;
    data_t         m_rd_word;

    int            total;
    int            passed;

    fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .count_push (count_push),
        .count_pop  (count_pop),
        .full       (full),
        .empty      (empty),
        .usedw      (usedw),
        .data_valid (data_valid),
        .overflow   (overflow),
        .underflow  (underflow),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM with a registered read port, as the FIFO top would connect it.
    always @(posedge clk) begin
        if (wr_en) mem[count_push] <= din;
        if (rd_en) ram_dout <= mem[count_pop];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_regs();
        int          sz;
        fifo_state_t exp_state;
        sz = model_q.size();
        exp_state = (sz == 0) ? EMPTY : ((sz == DEPTH) ? FULL : PARTIAL);
        chk("usedw", 32'(usedw), 32'(sz));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("state", 32'(state), 32'(exp_state));
        chk("count_push", 32'(count_push), 32'(wr_cnt % DEPTH));
        chk("count_pop", 32'(count_pop), 32'(rd_cnt % DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        if (m_dv) chk("data_out", 32'(ram_dout), 32'(m_rd_word));
    endtask

    // One clock: drive request, check gated enables, then check registered results.
    task automatic step(input bit p, input bit q, input data_t d);
        bit ew;
        bit er;
        int sz;
        push = p;
        pop  = q;
        din  = d;
        #1;
        sz = model_q.size();
        ew = p && (sz < DEPTH);
        er = q && (sz > 0);
        chk("wr_en", 32'(wr_en), 32'(ew));
        chk("rd_en", 32'(rd_en), 32'(er));
        @(posedge clk);
        if (p && sz == DEPTH) m_ovf = 1'b1;
        if (q && sz == 0) m_udf = 1'b1;
        m_dv = er;
        if (er) begin
            m_rd_word = model_q.pop_front();
            rd_cnt++;
        end
        if (ew) begin
            model_q.push_back(d);
            wr_cnt++;
        end
        #1;
        check_regs();
    endtask

    task automatic do_reset(input bit p, input bit q);
        push = p;
        pop  = q;
        din  = data_t'($urandom);
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        model_q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dv   = 1'b0;
        check_regs();
    endtask

    initial begin
        int   bias;
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        din    = '0;
        wr_cnt = 0;
        rd_cnt = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dv   = 1'b0;
        m_rd_word = '0;
        repeat (2) @(posedge clk);
        #1;

        // Three words in, three out, in order, one cycle of read latency.
        do_reset(1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        step(1'b1, 1'b0, 8'hA3);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Fill to DEPTH, then a rejected push.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, data_t'(8'h10 + i));
        step(1'b1, 1'b0, 8'hEE);

        // Push and pop together while full: only the pop is taken.
        step(1'b1, 1'b1, 8'hEF);
        step(1'b0, 1'b0, 8'h00);

        // Push and pop together while empty: only the push is taken.
        do_reset(1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 8'h00);

        // Steady state at occupancy 5 with simultaneous traffic; pointers wrap twice.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, data_t'($urandom));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, data_t'($urandom));
        step(1'b0, 1'b0, 8'h00);

        // Reset mid-stream with a pop pending.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, data_t'($urandom));
        step(1'b1, 1'b1, 8'h77);
        do_reset(1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00);

        // Random traffic in phases biased toward filling, draining and balance.
        for (int ph = 0; ph < 6; ph++) begin
            bias = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 15 : 50);
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 99) < 2) begin
                    do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end else begin
                    step(1'($urandom_range(0, 99) < bias),
                         1'($urandom_range(0, 99) < (100 - bias)),
                         data_t'($urandom));
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
